distributor_1x4: RTL and testbench

- Inverse of the datapath 4:1 selector: takes one 32-bit word plus a 2-bit destination select and delivers it to exactly one of four output channels (A..D).
- One registered pipeline stage with valid/ready handshakes on both sides; full throughput of one word per cycle.
- Per-channel delivered-word counters for debug and performance visibility.
- Sits between result producers (ALU/load unit) and their consumers (write-back, branch unit, store path, debug).

---
 rtl/distributor_1x4_pkg.sv | 19 +
 rtl/distributor_1x4_counter.sv | 38 +++
 rtl/distributor_1x4.sv | 124 ++++++++++++
 tb/tb_distributor_1x4.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/distributor_1x4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : distributor_1x4_pkg
// Description : Shared definitions for the 1:4 word distributor. Holds the
//               channel-select encoding and the default data width.
// Revision    : 1.0 - initial release
// ============================================================================
package distributor_1x4_pkg;

    localparam int DATA_W_DEFAULT = 32;

    // Destination channel encoding on in_select / the held select register.
    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

endpackage
`default_nettype wire

// File: rtl/distributor_1x4_counter.sv
`default_nettype none
// ============================================================================
// Module      : delivery_counter
// Description : Wrapping per-channel delivery counter with synchronous clear.
//               Clear has priority over increment; no saturation.
// Ports       : clk   - clock, rising edge
//               rst   - asynchronous active-high reset
//               clear - synchronous clear to zero
//               inc   - add one this cycle
//               count - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module delivery_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/distributor_1x4.sv
`default_nettype none
// ============================================================================
// Module      : distributor_1x4
// Description : Routes one DATA_W word to one of four channels (A..D) through
//               a single registered holding stage with valid/ready on both
//               sides. A word may be accepted in the same cycle the held word
//               drains, giving one word per cycle. Each channel has a
//               wrapping delivered-word counter.
// Ports       : clk, rst                 - clock / async active-high reset
//               in_data, in_select       - word and destination (00=A..11=D)
//               in_valid, in_ready       - producer handshake
//               output_x, valid_x        - per-channel data and valid
//               ready_x                  - per-channel consumer ready
//               cnt_clear                - synchronous clear of all counters
//               count_x                  - delivered words per channel
// Revision    : 1.0 - initial release
// ============================================================================
module distributor_1x4 #(
    parameter int DATA_W = distributor_1x4_pkg::DATA_W_DEFAULT,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_select,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] output_a,
    output logic [DATA_W-1:0] output_b,
    output logic [DATA_W-1:0] output_c,
    output logic [DATA_W-1:0] output_d,
    output logic              valid_a,
    output logic              valid_b,
    output logic              valid_c,
    output logic              valid_d,
    input  logic              ready_a,
    input  logic              ready_b,
    input  logic              ready_c,
    input  logic              ready_d,
    input  logic              cnt_clear,
    output logic [CNT_W-1:0]  count_a,
    output logic [CNT_W-1:0]  count_b,
    output logic [CNT_W-1:0]  count_c,
    output logic [CNT_W-1:0]  count_d
);

    import distributor_1x4_pkg::*;

    logic              r_full;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_sel;

    logic              w_sel_ready;
    logic              w_drain;
    logic              w_accept;
    logic [3:0]        w_inc;
    logic [CNT_W-1:0]  w_count [4];

    // Only the ready of the channel currently addressed by the held word
    // matters; the other three are deliberately ignored.
    always_comb begin
        w_sel_ready = 1'b0;
        case (r_sel)
            SEL_A:   w_sel_ready = ready_a;
            SEL_B:   w_sel_ready = ready_b;
            SEL_C:   w_sel_ready = ready_c;
            SEL_D:   w_sel_ready = ready_d;
            default: w_sel_ready = 1'b0;
        endcase
    end

    assign w_drain  = r_full && w_sel_ready;
    assign in_ready = !r_full || w_drain;
    assign w_accept = in_valid && in_ready;

    // Holding stage. An accept overwrites the register regardless of a
    // simultaneous drain, which is what makes back-to-back transfer possible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_sel  <= SEL_A;
        end else if (w_accept) begin
            r_full <= 1'b1;
            r_data <= in_data;
            r_sel  <= in_select;
        end else if (w_drain) begin
            r_full <= 1'b0;
        end
    end

    assign valid_a = r_full && (r_sel == SEL_A);
    assign valid_b = r_full && (r_sel == SEL_B);
    assign valid_c = r_full && (r_sel == SEL_C);
    assign valid_d = r_full && (r_sel == SEL_D);

    assign output_a = r_data;
    assign output_b = r_data;
    assign output_c = r_data;
    assign output_d = r_data;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_cnt
            assign w_inc[i] = w_drain && (r_sel == 2'(i));

            delivery_counter #(
                .CNT_W (CNT_W)
            ) u_delivery_counter (
                .clk   (clk),
                .rst   (rst),
                .clear (cnt_clear),
                .inc   (w_inc[i]),
                .count (w_count[i])
            );
        end
    endgenerate

    assign count_a = w_count[0];
    assign count_b = w_count[1];
    assign count_c = w_count[2];
    assign count_d = w_count[3];

endmodule
`default_nettype wire

// File: tb/tb_distributor_1x4.sv
`default_nettype none
// ============================================================================
// Module      : tb_distributor_1x4
// Description : Self-checking bench for distributor_1x4 (CNT_W=4 so counter
//               wrap is reachable). A negedge monitor keeps a queue of
//               accepted words and a model of the counters, and compares
//               channel valid/data, in_ready and counts every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_distributor_1x4;

    localparam int DW = 32;
    localparam int CW = 4;

    typedef struct packed {
        logic [1:0]    sel;
        logic [DW-1:0] data;
    } item_t;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic [1:0]    in_select;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] output_a, output_b, output_c, output_d;
    logic          valid_a, valid_b, valid_c, valid_d;
    logic          ready_a, ready_b, ready_c, ready_d;
    logic          cnt_clear;
    logic [CW-1:0] count_a, count_b, count_c, count_d;

    int            n_checks;
    int            n_errors;
    item_t         q[$];
    logic [CW-1:0] mcnt [4];
    logic          acc_flag;

    distributor_1x4 #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_select (in_select),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .output_a  (output_a),
        .output_b  (output_b),
        .output_c  (output_c),
        .output_d  (output_d),
        .valid_a   (valid_a),
        .valid_b   (valid_b),
        .valid_c   (valid_c),
        .valid_d   (valid_d),
        .ready_a   (ready_a),
        .ready_b   (ready_b),
        .ready_c   (ready_c),
        .ready_d   (ready_d),
        .cnt_clear (cnt_clear),
        .count_a   (count_a),
        .count_b   (count_b),
        .count_c   (count_c),
        .count_d   (count_d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] chan_out(input logic [1:0] s);
        case (s)
            2'd0:    return output_a;
            2'd1:    return output_b;
            2'd2:    return output_c;
            default: return output_d;
        endcase
    endfunction

    // Monitor / scoreboard: compares current DUT state to the model, then
    // advances the model to what the next rising edge should produce.
    always @(negedge clk) begin
        logic [3:0] rdy;
        logic [3:0] vld;
        logic       m_full, m_drain, m_rdy;
        logic [1:0] hs;
        rdy = {ready_d, ready_c, ready_b, ready_a};
        vld = {valid_d, valid_c, valid_b, valid_a};
        if (rst) begin
            q.delete();
            for (int i = 0; i < 4; i++) mcnt[i] = '0;
            acc_flag = 1'b0;
            check("rst_valid", 32'(vld), 32'h0);
            check("rst_ready", 32'(in_ready), 32'h1);
        end else begin
            m_full  = (q.size() != 0);
            hs      = m_full ? q[0].sel : 2'd0;
            m_drain = m_full && rdy[hs];
            m_rdy   = !m_full || m_drain;
            check("valid_vec", 32'(vld), m_full ? 32'(4'b0001 << hs) : 32'h0);
            if (m_full) check("chan_data", chan_out(hs), q[0].data);
            check("in_ready", 32'(in_ready), 32'(m_rdy));
            check("count_a", 32'(count_a), 32'(mcnt[0]));
            check("count_b", 32'(count_b), 32'(mcnt[1]));
            check("count_c", 32'(count_c), 32'(mcnt[2]));
            check("count_d", 32'(count_d), 32'(mcnt[3]));
            acc_flag = in_valid && m_rdy;
            for (int i = 0; i < 4; i++) begin
                if (cnt_clear) mcnt[i] = '0;
                else if (m_drain && (hs == 2'(i))) mcnt[i] = mcnt[i] + 1'b1;
            end
            if (m_drain) void'(q.pop_front());
            if (acc_flag) q.push_back('{sel: in_select, data: in_data});
        end
    end

    // Presents a word and returns (at posedge+1) once it has been accepted;
    // ncyc reports how many edges that took.
    task automatic send(input logic [1:0] s, input logic [DW-1:0] d, output int ncyc);
        in_valid  = 1'b1;
        in_select = s;
        in_data   = d;
        ncyc      = 0;
        do begin
            @(posedge clk);
            #1;
            ncyc++;
        end while (!acc_flag && ncyc < 50);
        if (!acc_flag) check("send_timeout", 32'(ncyc), 32'h0);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clear();
        cnt_clear = 1'b1;
        tick(1);
        cnt_clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_checks  = 0;
        n_errors  = 0;
        acc_flag  = 1'b0;
        rst       = 1'b1;
        in_data   = '0;
        in_select = 2'd0;
        in_valid  = 1'b0;
        cnt_clear = 1'b0;
        {ready_d, ready_c, ready_b, ready_a} = 4'hF;

        // Reset state
        #1;
        check("init_valid", 32'({valid_d, valid_c, valid_b, valid_a}), 32'h0);
        check("init_ready", 32'(in_ready), 32'h1);
        check("init_out_a", output_a, 32'h0);
        check("init_cnt_d", 32'(count_d), 32'h0);
        tick(2);
        rst = 1'b0;
        tick(1);

        // Single routing to C
        send(2'd2, 32'hDEADBEEF, n);
        in_valid = 1'b0;
        check("single_valid_c", 32'(valid_c), 32'h1);
        check("single_out_c", output_c, 32'hDEADBEEF);
        check("single_others", 32'({valid_d, valid_b, valid_a}), 32'h0);
        tick(1);
        check("single_count_c", 32'(count_c), 32'h1);
        tick(1);

        // Streaming: 8 words, select cycling, one per cycle
        pulse_clear();
        for (int i = 0; i < 8; i++) begin
            send(2'(i), 32'(i), n);
            check("stream_lat", 32'(n), 32'h1);
        end
        in_valid = 1'b0;
        tick(3);
        check("stream_cnt_a", 32'(count_a), 32'h2);
        check("stream_cnt_b", 32'(count_b), 32'h2);
        check("stream_cnt_c", 32'(count_c), 32'h2);
        check("stream_cnt_d", 32'(count_d), 32'h2);

        // Backpressure on B with another word waiting for A
        ready_b = 1'b0;
        send(2'd1, 32'h1234, n);
        in_valid  = 1'b1;
        in_select = 2'd0;
        in_data   = 32'h5678;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("bp_in_ready", 32'(in_ready), 32'h0);
            check("bp_valid_b", 32'(valid_b), 32'h1);
            check("bp_out_b", output_b, 32'h1234);
        end
        ready_b = 1'b1;
        tick(1);
        check("bp_b2b_accept", 32'(acc_flag), 32'h1);
        in_valid = 1'b0;
        check("bp_next_valid_a", 32'(valid_a), 32'h1);
        check("bp_next_out_a", output_a, 32'h5678);
        tick(2);

        // Counter wrap and clear priority on D
        pulse_clear();
        for (int i = 0; i < 17; i++) send(2'd3, 32'h100 + 32'(i), n);
        in_valid = 1'b0;
        tick(3);
        check("wrap_count_d", 32'(count_d), 32'h1);
        send(2'd3, 32'hAA, n);
        in_valid  = 1'b0;
        cnt_clear = 1'b1;
        tick(1);
        cnt_clear = 1'b0;
        check("clr_vs_inc_d", 32'(count_d), 32'h0);
        check("clr_drained_d", 32'(valid_d), 32'h0);
        tick(1);

        // Unselected readies are ignored
        {ready_d, ready_c, ready_b, ready_a} = 4'b1110;
        send(2'd0, 32'hA0A0A0A0, n);
        in_valid = 1'b0;
        tick(3);
        check("ign_in_ready", 32'(in_ready), 32'h0);
        check("ign_valid_a", 32'(valid_a), 32'h1);
        ready_a = 1'b1;
        tick(1);
        check("ign_drained", 32'(valid_a), 32'h0);
        check("ign_count_a", 32'(count_a), 32'h1);

        // Reset mid-transfer: held word dropped, counts cleared at once
        ready_c = 1'b0;
        send(2'd2, 32'hC0FFEE00, n);
        in_valid = 1'b0;
        tick(1);
        #2;
        rst = 1'b1;
        #1;
        check("mrst_valid_c", 32'(valid_c), 32'h0);
        check("mrst_count_a", 32'(count_a), 32'h0);
        check("mrst_out_c", output_c, 32'h0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        ready_c = 1'b1;
        check("post_rst_ready", 32'(in_ready), 32'h1);
        check("post_rst_out_a", output_a, 32'h0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
